// File: rtl/dcache_pkg.sv
// Shared types and helpers for the write-back data cache: FSM states, block geometry,
// store byte-lane decode and byte merge.
package dcache_pkg;

   localparam int OFFSET_W      = 5;
   localparam int BLOCK_W       = 256;
   localparam int WORDS_PER_BLK = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WB,
      S_FILL,
      S_RESP,
      S_FL_SCAN,
      S_FL_WB,
      S_FL_DONE
   } state_t;

   // Lanes lo .. lo+n-1 (n = size, 0 meaning 4); lanes beyond 3 fall off the word.
   function automatic logic [3:0] size_to_lanes(input logic [1:0] lo, input logic [1:0] size);
      logic [2:0] first;
      logic [2:0] last_x;
      logic [3:0] lanes;
      first  = {1'b0, lo};
      last_x = first + ((size == 2'd0) ? 3'd4 : {1'b0, size});
      for (int k = 0; k < 4; k++) begin
         lanes[k] = (3'(k) >= first) && (3'(k) < last_x);
      end
      return lanes;
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  lanes);
      logic [31:0] res;
      for (int k = 0; k < 4; k++) begin
         res[8*k +: 8] = lanes[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dcache_plru.sv
// Per-set tree pseudo-LRU replacement state: 1 bit/set for 2 ways, 3 bits/set for 4 ways,
// nothing for direct-mapped. Bits point toward the side to replace next.
module dcache_plru
   import dcache_pkg::*;
#(
   parameter int NUM_SETS = 64,
   parameter int NUM_WAYS = 2,
   parameter int IDX_W    = 6,
   parameter int WAY_W    = 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             touch_en,
   input  logic [IDX_W-1:0] touch_set,
   input  logic [WAY_W-1:0] touch_way,
   input  logic [IDX_W-1:0] vict_set,
   output logic [WAY_W-1:0] vict_way
);

   if (NUM_WAYS == 2) begin : g_two
      logic [NUM_SETS-1:0] bits_q, bits_d;

      always_comb begin
         bits_d = bits_q;
         if (touch_en) bits_d[touch_set] = ~touch_way[0];
      end

      always_ff @(posedge CLK or negedge RESET) begin
         if (!RESET) bits_q <= '0;
         else        bits_q <= bits_d;
      end

      assign vict_way = bits_q[vict_set];
   end else if (NUM_WAYS == 4) begin : g_four
      // [0] root (1 = right pair), [1] picks within ways 0/1, [2] within ways 2/3
      logic [NUM_SETS-1:0][2:0] tree_q, tree_d;
      logic [2:0]               vict_bits;

      always_comb begin
         tree_d = tree_q;
         if (touch_en) begin
            tree_d[touch_set][0] = ~touch_way[1];
            if (touch_way[1]) tree_d[touch_set][2] = ~touch_way[0];
            else              tree_d[touch_set][1] = ~touch_way[0];
         end
      end

      always_ff @(posedge CLK or negedge RESET) begin
         if (!RESET) tree_q <= '0;
         else        tree_q <= tree_d;
      end

      assign vict_bits = tree_q[vict_set];
      assign vict_way  = {vict_bits[0], vict_bits[0] ? vict_bits[2] : vict_bits[1]};
   end else begin : g_one
      logic unused_plru;
      assign unused_plru = ^{CLK, RESET, touch_en, touch_set, touch_way, vict_set};
      assign vict_way    = '0;
   end

endmodule

// File: rtl/dcache_wb.sv
// Write-back, write-allocate set-associative data cache with block memory interface and flush.
// Define DCACHE_STATS_EN to add saturating hit/miss counters (hit_count_out, miss_count_out).
module dcache_wb
   import dcache_pkg::*;
#(
   parameter int NUM_SETS = 64,
   parameter int NUM_WAYS = 2,
   parameter int ADDR_W   = 32
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [ADDR_W-1:0]  addr_in,
   input  logic               read_in,
   input  logic               write_in,
   input  logic [31:0]        write_data_in,
   input  logic [1:0]         write_size_in,
   output logic [31:0]        read_data_out,
   output logic               data_valid_out,
   input  logic               flush_in,
   output logic               flush_done_out,
   output logic [ADDR_W-1:0]  block_addr_out,
   output logic               blk_read_out,
   output logic               blk_write_out,
   output logic [BLOCK_W-1:0] block_write_out,
   input  logic [BLOCK_W-1:0] block_read_in,
   input  logic               block_read_valid_in,
   input  logic               block_write_valid_in
`ifdef DCACHE_STATS_EN
  ,output logic [31:0]        hit_count_out,
   output logic [31:0]        miss_count_out
`endif
);

   localparam int IDX_W  = $clog2(NUM_SETS);
   localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam int TAG_W  = ADDR_W - OFFSET_W - IDX_W;
   localparam int WORD_W = $clog2(WORDS_PER_BLK);
   localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);
   localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);

   logic [BLOCK_W-1:0] data_mem [NUM_SETS][NUM_WAYS];
   logic [TAG_W-1:0]   tag_mem  [NUM_SETS][NUM_WAYS];

   state_t                         state_q, state_d;
   logic [IDX_W-1:0]               set_q, set_d;
   logic [WAY_W-1:0]               way_q, way_d;
   logic                           blk_rd_q, blk_rd_d, blk_wr_q, blk_wr_d;
   logic                           flush_done_q, flush_done_d;
   logic [ADDR_W-1:0]              blk_addr_q, blk_addr_d;
   logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q, valid_d, dirty_q, dirty_d;

   logic               req, hit, inv_found, do_access, do_store, fill_we;
   logic [IDX_W-1:0]   req_idx;
   logic [TAG_W-1:0]   req_tag;
   logic [WORD_W-1:0]  req_word;
   logic [WAY_W-1:0]   hit_way, inv_way, plru_way, victim;
   logic [31:0]        hit_word, merged_word;
   logic               scan_last;
   logic [IDX_W-1:0]   scan_set_nx;
   logic [WAY_W-1:0]   scan_way_nx;

   assign req      = read_in | write_in;
   assign req_idx  = addr_in[OFFSET_W +: IDX_W];
   assign req_tag  = addr_in[ADDR_W-1 -: TAG_W];
   assign req_word = addr_in[2 +: WORD_W];

   // Downward walk so the lowest-numbered invalid way wins.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (valid_q[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[req_idx][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
   end

   assign victim      = inv_found ? inv_way : plru_way;
   assign hit_word    = data_mem[req_idx][hit_way][{req_word, 5'b00000} +: 32];
   assign merged_word = merge_bytes(hit_word, write_data_in,
                                    size_to_lanes(addr_in[1:0], write_size_in));

   // RESP re-runs the access against the freshly filled line, which now hits.
   assign do_access = req && hit && ((state_q == S_IDLE) || (state_q == S_RESP));
   assign do_store  = do_access && write_in;

   assign data_valid_out  = !req || do_access;
   assign read_data_out   = do_access ? hit_word : '0;
   assign blk_read_out    = blk_rd_q;
   assign blk_write_out   = blk_wr_q;
   assign flush_done_out  = flush_done_q;
   assign block_addr_out  = blk_addr_q;
   assign block_write_out = blk_wr_q ? data_mem[set_q][way_q] : '0;

   assign scan_last   = (set_q == LAST_SET) && (way_q == LAST_WAY);
   assign scan_set_nx = (way_q == LAST_WAY) ? set_q + 1'b1 : set_q;
   assign scan_way_nx = (way_q == LAST_WAY) ? '0 : way_q + 1'b1;

   dcache_plru #(
      .NUM_SETS (NUM_SETS),
      .NUM_WAYS (NUM_WAYS),
      .IDX_W    (IDX_W),
      .WAY_W    (WAY_W)
   ) u_plru (
      .CLK       (CLK),
      .RESET     (RESET),
      .touch_en  (do_access),
      .touch_set (req_idx),
      .touch_way (hit_way),
      .vict_set  (req_idx),
      .vict_way  (plru_way)
   );

   always_comb begin
      state_d      = state_q;
      set_d        = set_q;
      way_d        = way_q;
      blk_rd_d     = blk_rd_q;
      blk_wr_d     = blk_wr_q;
      blk_addr_d   = blk_addr_q;
      flush_done_d = 1'b0;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      fill_we      = 1'b0;

      if (do_store) dirty_d[req_idx][hit_way] = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (req && !hit) begin
               set_d = req_idx;
               way_d = victim;
               if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
                  state_d    = S_WB;
                  blk_wr_d   = 1'b1;
                  blk_addr_d = {tag_mem[req_idx][victim], req_idx, 5'b00000};
               end else begin
                  state_d    = S_FILL;
                  blk_rd_d   = 1'b1;
                  blk_addr_d = {addr_in[ADDR_W-1:OFFSET_W], 5'b00000};
               end
            end else if (!req && flush_in) begin
               state_d = S_FL_SCAN;
               set_d   = '0;
               way_d   = '0;
            end
         end
         S_WB: begin
            if (block_write_valid_in) begin
               state_d    = S_FILL;
               blk_wr_d   = 1'b0;
               blk_rd_d   = 1'b1;
               blk_addr_d = {addr_in[ADDR_W-1:OFFSET_W], 5'b00000};
            end
         end
         S_FILL: begin
            if (block_read_valid_in) begin
               state_d               = S_RESP;
               blk_rd_d              = 1'b0;
               fill_we               = 1'b1;
               valid_d[set_q][way_q] = 1'b1;
               dirty_d[set_q][way_q] = 1'b0;
            end
         end
         S_RESP: state_d = S_IDLE;
         S_FL_SCAN, S_FL_WB: begin
            if ((state_q == S_FL_SCAN) && valid_q[set_q][way_q] && dirty_q[set_q][way_q]) begin
               state_d    = S_FL_WB;
               blk_wr_d   = 1'b1;
               blk_addr_d = {tag_mem[set_q][way_q], set_q, 5'b00000};
            end else if ((state_q == S_FL_SCAN) || block_write_valid_in) begin
               blk_wr_d              = 1'b0;
               valid_d[set_q][way_q] = 1'b0;
               dirty_d[set_q][way_q] = 1'b0;
               if (scan_last) begin
                  state_d      = S_FL_DONE;
                  flush_done_d = 1'b1;
               end else begin
                  state_d = S_FL_SCAN;
                  set_d   = scan_set_nx;
                  way_d   = scan_way_nx;
               end
            end
         end
         S_FL_DONE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q      <= S_IDLE;
         set_q        <= '0;
         way_q        <= '0;
         blk_rd_q     <= 1'b0;
         blk_wr_q     <= 1'b0;
         blk_addr_q   <= '0;
         flush_done_q <= 1'b0;
         valid_q      <= '0;
         dirty_q      <= '0;
      end else begin
         state_q      <= state_d;
         set_q        <= set_d;
         way_q        <= way_d;
         blk_rd_q     <= blk_rd_d;
         blk_wr_q     <= blk_wr_d;
         blk_addr_q   <= blk_addr_d;
         flush_done_q <= flush_done_d;
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
      end
   end

   // Line storage carries no reset; valid bits gate every use of it.
   always_ff @(posedge CLK) begin
      if (fill_we) begin
         data_mem[set_q][way_q] <= block_read_in;
         tag_mem[set_q][way_q]  <= req_tag;
      end else if (do_store) begin
         data_mem[req_idx][hit_way][{req_word, 5'b00000} +: 32] <= merged_word;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if ((state_q == S_IDLE) && req) begin
         if (hit) begin
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
         end else begin
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count_out  = hit_cnt_q;
   assign miss_count_out = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// Directed self-checking bench for dcache_wb with a behavioural block-memory responder.
module tb_dcache_wb;

   logic         CLK = 1'b0;
   logic         RESET;
   logic [31:0]  addr_in;
   logic         read_in, write_in;
   logic [31:0]  write_data_in;
   logic [1:0]   write_size_in;
   logic [31:0]  read_data_out;
   logic         data_valid_out;
   logic         flush_in;
   logic         flush_done_out;
   logic [31:0]  block_addr_out;
   logic         blk_read_out, blk_write_out;
   logic [255:0] block_write_out;
   logic [255:0] block_read_in;
   logic         block_read_valid_in, block_write_valid_in;
`ifdef DCACHE_STATS_EN
   logic [31:0]  hit_count_out, miss_count_out;
`endif

   int errors = 0;
   int checks = 0;

   logic [255:0] mem [logic [31:0]];
   byte          ev_kind [$];
   logic [31:0]  ev_addr [$];
   logic [255:0] ev_data [$];
   int           rd_delay = 0;
   int           overlap_cnt = 0;

   dcache_wb dut (
      .CLK                  (CLK),
      .RESET                (RESET),
      .addr_in              (addr_in),
      .read_in              (read_in),
      .write_in             (write_in),
      .write_data_in        (write_data_in),
      .write_size_in        (write_size_in),
      .read_data_out        (read_data_out),
      .data_valid_out       (data_valid_out),
      .flush_in             (flush_in),
      .flush_done_out       (flush_done_out),
      .block_addr_out       (block_addr_out),
      .blk_read_out         (blk_read_out),
      .blk_write_out        (blk_write_out),
      .block_write_out      (block_write_out),
      .block_read_in        (block_read_in),
      .block_read_valid_in  (block_read_valid_in),
      .block_write_valid_in (block_write_valid_in)
`ifdef DCACHE_STATS_EN
     ,.hit_count_out        (hit_count_out),
      .miss_count_out       (miss_count_out)
`endif
   );

   always #5 CLK = ~CLK;

   // Untouched blocks read back as word i = 0xC0000000 + block address + 4*i.
   function automatic logic [255:0] mem_get(input logic [31:0] a);
      logic [255:0] b;
      if (mem.exists(a)) return mem[a];
      for (int i = 0; i < 8; i++) b[32*i +: 32] = 32'hC000_0000 + a + 32'(4 * i);
      return b;
   endfunction

   initial begin
      int  rd_wait;
      bit  rd_active;
      rd_wait = 0;
      rd_active = 0;
      block_read_valid_in  = 1'b0;
      block_write_valid_in = 1'b0;
      block_read_in        = '0;
      forever begin
         @(negedge CLK);
         block_read_valid_in  = 1'b0;
         block_write_valid_in = 1'b0;
         if (blk_read_out && blk_write_out) overlap_cnt++;
         if (blk_write_out) begin
            mem[block_addr_out] = block_write_out;
            ev_kind.push_back("W");
            ev_addr.push_back(block_addr_out);
            ev_data.push_back(block_write_out);
            block_write_valid_in = 1'b1;
         end
         if (blk_read_out) begin
            if (!rd_active) begin
               rd_active = 1;
               ev_kind.push_back("R");
               ev_addr.push_back(block_addr_out);
               ev_data.push_back('0);
            end
            if (rd_wait >= rd_delay) begin
               block_read_in       = mem_get(block_addr_out);
               block_read_valid_in = 1'b1;
               rd_wait   = 0;
               rd_active = 0;
            end else begin
               rd_wait++;
            end
         end else begin
            rd_wait   = 0;
            rd_active = 0;
         end
      end
   end

   task automatic cpu_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz, output int cyc, output logic [31:0] rd);
      @(posedge CLK); #1;
      addr_in = a; read_in = !wr; write_in = wr; write_data_in = d; write_size_in = sz;
      cyc = 0;
      rd  = '0;
      forever begin
         @(negedge CLK);
         cyc++;
         if (data_valid_out) begin
            rd = read_data_out;
            break;
         end
         if (cyc >= 400) begin
            checks++; errors++;
            $display("FAIL access_timeout addr=%h: no data_valid_out within %0d cycles", a, cyc);
            break;
         end
      end
      @(posedge CLK); #1;
      read_in = 1'b0; write_in = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b0; addr_in = '0; read_in = 0; write_in = 0; write_data_in = '0;
      write_size_in = '0; flush_in = 0;
      #3;
      checks++; if (data_valid_out !== 1'b1) begin errors++; $display("FAIL reset_dv got=%b want=1", data_valid_out); end
      checks++; if (blk_read_out !== 1'b0) begin errors++; $display("FAIL reset_blk_rd got=%b want=0", blk_read_out); end
      checks++; if (blk_write_out !== 1'b0) begin errors++; $display("FAIL reset_blk_wr got=%b want=0", blk_write_out); end
      checks++; if (flush_done_out !== 1'b0) begin errors++; $display("FAIL reset_flush_done got=%b want=0", flush_done_out); end
      checks++; if (block_addr_out !== 32'h0) begin errors++; $display("FAIL reset_blk_addr got=%h want=0", block_addr_out); end
      checks++; if (read_data_out !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h want=0", read_data_out); end
      checks++; if (block_write_out !== 256'h0) begin errors++; $display("FAIL reset_blk_wdata got=%h want=0", block_write_out); end
      @(negedge CLK);
      RESET = 1'b1;
   endtask

   task automatic test_cold_load();
      int cyc; logic [31:0] rd; int n;
      n = ev_kind.size();
      cpu_access(0, 32'h1000, '0, 2'd0, cyc, rd);
      checks++; if (ev_kind.size() !== n + 1) begin errors++; $display("FAIL cold_ev_count got=%0d want=%0d", ev_kind.size(), n + 1); end
      checks++; if (ev_kind[n] !== "R" || ev_addr[n] !== 32'h1000) begin errors++; $display("FAIL cold_blk_read kind=%c addr=%h want R 00001000", ev_kind[n], ev_addr[n]); end
      checks++; if (rd !== 32'hC000_1000) begin errors++; $display("FAIL cold_rdata got=%h want=c0001000", rd); end
      checks++; if (cyc !== 3) begin errors++; $display("FAIL cold_latency got=%0d want=3", cyc); end
      cpu_access(0, 32'h1000, '0, 2'd0, cyc, rd);
      checks++; if (cyc !== 1) begin errors++; $display("FAIL hit_latency got=%0d want=1", cyc); end
      checks++; if (rd !== 32'hC000_1000) begin errors++; $display("FAIL hit_rdata got=%h want=c0001000", rd); end
`ifdef DCACHE_STATS_EN
      checks++; if (hit_count_out !== 32'd1) begin errors++; $display("FAIL stats_hit got=%0d want=1", hit_count_out); end
      checks++; if (miss_count_out !== 32'd1) begin errors++; $display("FAIL stats_miss got=%0d want=1", miss_count_out); end
`endif
   endtask

   task automatic test_store_merge();
      int cyc; logic [31:0] rd; int n;
      n = ev_kind.size();
      cpu_access(1, 32'h1004, 32'hAABB_CCDD, 2'd1, cyc, rd);
      checks++; if (cyc !== 1) begin errors++; $display("FAIL store_hit_latency got=%0d want=1", cyc); end
      cpu_access(0, 32'h1004, '0, 2'd0, cyc, rd);
      checks++; if (rd !== 32'hC000_10DD) begin errors++; $display("FAIL store_size1 got=%h want=c00010dd", rd); end
      cpu_access(1, 32'h1006, 32'h1122_3344, 2'd2, cyc, rd);
      cpu_access(1, 32'h1007, 32'h5566_7788, 2'd3, cyc, rd);
      cpu_access(1, 32'h1008, 32'hCAFE_F00D, 2'd0, cyc, rd);
      cpu_access(0, 32'h1004, '0, 2'd0, cyc, rd);
      checks++; if (rd !== 32'h5522_10DD) begin errors++; $display("FAIL store_lanes_clip got=%h want=552210dd", rd); end
      cpu_access(0, 32'h1008, '0, 2'd0, cyc, rd);
      checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL store_size4 got=%h want=cafef00d", rd); end
      checks++; if (ev_kind.size() !== n) begin errors++; $display("FAIL store_no_mem_traffic got=%0d want=%0d", ev_kind.size(), n); end
   endtask

   task automatic test_evict();
      int cyc; logic [31:0] rd; int n;
      cpu_access(0, 32'h1800, '0, 2'd0, cyc, rd);
      checks++; if (rd !== 32'hC000_1800 || cyc !== 3) begin errors++; $display("FAIL evict_fill2 rd=%h cyc=%0d want c0001800/3", rd, cyc); end
      n = ev_kind.size();
      cpu_access(0, 32'h2000, '0, 2'd0, cyc, rd);
      checks++; if (ev_kind.size() !== n + 2) begin errors++; $display("FAIL evict_ev_count got=%0d want=%0d", ev_kind.size(), n + 2); end
      checks++; if (ev_kind[n] !== "W" || ev_addr[n] !== 32'h1000) begin errors++; $display("FAIL evict_wb_first kind=%c addr=%h want W 00001000", ev_kind[n], ev_addr[n]); end
      checks++; if (ev_data[n][63:32] !== 32'h5522_10DD || ev_data[n][95:64] !== 32'hCAFE_F00D) begin errors++; $display("FAIL evict_wb_data w1=%h w2=%h want 552210dd cafef00d", ev_data[n][63:32], ev_data[n][95:64]); end
      checks++; if (ev_kind[n+1] !== "R" || ev_addr[n+1] !== 32'h2000) begin errors++; $display("FAIL evict_fill_next kind=%c addr=%h want R 00002000", ev_kind[n+1], ev_addr[n+1]); end
      checks++; if (rd !== 32'hC000_2000 || cyc !== 4) begin errors++; $display("FAIL evict_resp rd=%h cyc=%0d want c0002000/4", rd, cyc); end
      cpu_access(0, 32'h1800, '0, 2'd0, cyc, rd);
      checks++; if (cyc !== 1) begin errors++; $display("FAIL plru_kept_mru got=%0d want=1", cyc); end
   endtask

   task automatic test_slow_fill();
      int cyc; int rd_hi; int unstable; bit done; logic [31:0] rd;
      rd_delay = 20;
      @(posedge CLK); #1;
      addr_in = 32'h4020; read_in = 1'b1; write_in = 1'b0;
      cyc = 0; rd_hi = 0; unstable = 0; done = 0; rd = '0;
      while (!done && cyc < 200) begin
         @(negedge CLK);
         cyc++;
         if (data_valid_out) begin
            done = 1;
            rd = read_data_out;
         end else if (blk_read_out) begin
            rd_hi++;
            if (block_addr_out !== 32'h4020) unstable++;
         end
      end
      @(posedge CLK); #1;
      read_in = 1'b0;
      rd_delay = 0;
      checks++; if (!done) begin errors++; $display("FAIL slow_timeout got=%0d cycles want completion", cyc); end
      checks++; if (cyc !== 23) begin errors++; $display("FAIL slow_latency got=%0d want=23", cyc); end
      checks++; if (rd_hi !== 21) begin errors++; $display("FAIL slow_rd_cycles got=%0d want=21", rd_hi); end
      checks++; if (unstable !== 0) begin errors++; $display("FAIL slow_addr_stable got=%0d want=0", unstable); end
      checks++; if (rd !== 32'hC000_4020) begin errors++; $display("FAIL slow_rdata got=%h want=c0004020", rd); end
   endtask

   task automatic test_flush();
      int cyc; logic [31:0] rd; int n; int t; int pulses; int extra;
      cpu_access(1, 32'h2000, 32'h1234_5678, 2'd0, cyc, rd);
      cpu_access(1, 32'h4020, 32'h9ABC_DEF0, 2'd0, cyc, rd);
      n = ev_kind.size();
      pulses = 0; extra = 0; t = 0;
      @(posedge CLK); #1;
      flush_in = 1'b1;
      while (pulses == 0 && t < 1000) begin
         @(negedge CLK);
         t++;
         if (flush_done_out) pulses++;
      end
      @(posedge CLK); #1;
      flush_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         if (flush_done_out) extra++;
      end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL flush_done_seen got=%0d want=1", pulses); end
      checks++; if (extra !== 0) begin errors++; $display("FAIL flush_done_width extra=%0d want=0", extra); end
      checks++; if (ev_kind.size() !== n + 2) begin errors++; $display("FAIL flush_wb_count got=%0d want=%0d", ev_kind.size() - n, 2); end
      checks++; if (ev_kind[n] !== "W" || ev_addr[n] !== 32'h2000 || ev_data[n][31:0] !== 32'h1234_5678) begin errors++; $display("FAIL flush_wb0 kind=%c addr=%h w0=%h want W 00002000 12345678", ev_kind[n], ev_addr[n], ev_data[n][31:0]); end
      checks++; if (ev_kind[n+1] !== "W" || ev_addr[n+1] !== 32'h4020 || ev_data[n+1][31:0] !== 32'h9ABC_DEF0) begin errors++; $display("FAIL flush_wb1 kind=%c addr=%h w0=%h want W 00004020 9abcdef0", ev_kind[n+1], ev_addr[n+1], ev_data[n+1][31:0]); end
      cpu_access(0, 32'h2000, '0, 2'd0, cyc, rd);
      checks++; if (cyc !== 3 || rd !== 32'h1234_5678) begin errors++; $display("FAIL flush_reload cyc=%0d rd=%h want 3/12345678", cyc, rd); end
      cpu_access(0, 32'h1800, '0, 2'd0, cyc, rd);
      checks++; if (cyc !== 3) begin errors++; $display("FAIL flush_invalidated got=%0d want=3", cyc); end
   endtask

   task automatic test_reset_mid_fill();
      int cyc; logic [31:0] rd; int t; bit seen;
      rd_delay = 50;
      @(posedge CLK); #1;
      addr_in = 32'h6040; read_in = 1'b1;
      seen = 0; t = 0;
      while (!seen && t < 10) begin
         @(negedge CLK);
         t++;
         if (blk_read_out) seen = 1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL rst_fill_start got=%b want=1", seen); end
      #2 RESET = 1'b0;
      #1;
      checks++; if (blk_read_out !== 1'b0) begin errors++; $display("FAIL rst_async_blk_rd got=%b want=0", blk_read_out); end
      read_in = 1'b0;
      #1;
      checks++; if (data_valid_out !== 1'b1) begin errors++; $display("FAIL rst_dv_idle got=%b want=1", data_valid_out); end
      RESET = 1'b1;
      rd_delay = 0;
      cpu_access(0, 32'h6040, '0, 2'd0, cyc, rd);
      checks++; if (cyc !== 3 || rd !== 32'hC000_6040) begin errors++; $display("FAIL rst_refill cyc=%0d rd=%h want 3/c0006040", cyc, rd); end
      cpu_access(0, 32'h2000, '0, 2'd0, cyc, rd);
      checks++; if (cyc !== 3) begin errors++; $display("FAIL rst_cleared_valid got=%0d want=3", cyc); end
   endtask

   initial begin
      test_reset();
      test_cold_load();
      test_store_merge();
      test_evict();
      test_slow_fill();
      test_flush();
      test_reset_mid_fill();
      checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL blk_overlap got=%0d want=0", overlap_cnt); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
